// File: rtl/hopmode_sched.sv
// Hop-mode scheduler: arbitrates page/inquiry/scan requests, sequences the response
// and connection phases, and drives the registered mode selects and response counters.
module hopmode_sched #(
  parameter int PAGERESP_TO = 8,
  parameter int NEWCONN_TO  = 32
) (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       ms_tslot_p,
  input  logic       req_page,
  input  logic       req_inquiry,
  input  logic       req_pscan,
  input  logic       req_iscan,
  input  logic       regi_interlace_en,
  input  logic [7:0] regi_scan_half,
  input  logic       ps_rxid_p,
  input  logic       page_rxid_p,
  input  logic       is_rxid_p,
  input  logic       ir_fhs_tx_p,
  input  logic       psrxfhs_succ_p,
  input  logic       ps_N_incr_p,
  input  logic       m_tslot_p,
  input  logic       mpr_fhs_ack_p,
  input  logic       conn_poll_p,
  input  logic       detach_p,
  output logic       ps,
  output logic       gips,
  output logic       is,
  output logic       giis,
  output logic       page,
  output logic       inquiry,
  output logic       mpr,
  output logic       spr,
  output logic       ir,
  output logic       conns,
  output logic       prs_clock_frozen,
  output logic       prm_clock_frozen,
  output logic [5:0] counter_clkN1,
  output logic [5:0] counter_clkE1,
  output logic [4:0] counter_isFHS,
  output logic       resp_to_p
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PSCAN, ST_ISCAN, ST_PAGE, ST_INQ, ST_SPR,
    ST_MPR, ST_IR, ST_SCONN, ST_MCONN, ST_CONN
  } state_t;

  localparam logic [5:0] PRTO = 6'(PAGERESP_TO);
  localparam logic [5:0] NCTO = 6'(NEWCONN_TO);

  state_t     state, state_n;
  logic       half_odd, half_odd_n;
  logic [7:0] half_cnt, half_cnt_n, half_cnt_inc, scan_half_eff;
  logic [5:0] to_cnt, to_cnt_n, to_cnt_inc;
  logic       fhs_ok, fhs_ok_n;
  logic [5:0] clkn1_n, clkn1_cleared, clke1_n;
  logic [4:0] isfhs_n;
  logic       timeout_n;
  logic       timed_n, entering;
  state_t     slave_exit, master_exit;

  assign scan_half_eff = (regi_scan_half == 8'd0) ? 8'd1 : regi_scan_half;
  assign half_cnt_inc  = half_cnt + 8'd1;
  assign to_cnt_inc    = to_cnt + 6'd1;
  assign slave_exit    = req_pscan ? ST_PSCAN : ST_IDLE;
  assign master_exit   = req_page ? ST_PAGE : ST_IDLE;
  assign clkn1_cleared = psrxfhs_succ_p ? {counter_clkN1[5:1], 1'b0} : counter_clkN1;

  // Next-state and next-counter values; entry/exit side effects are applied after the case.
  always_comb begin
    state_n    = state;
    half_odd_n = half_odd;
    half_cnt_n = half_cnt;
    to_cnt_n   = ms_tslot_p ? to_cnt_inc : to_cnt;
    fhs_ok_n   = fhs_ok;
    clkn1_n    = counter_clkN1;
    clke1_n    = counter_clkE1;
    isfhs_n    = counter_isFHS;
    timeout_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ms_tslot_p) begin
          if (req_page)         state_n = ST_PAGE;
          else if (req_inquiry) state_n = ST_INQ;
          else if (req_pscan)   state_n = ST_PSCAN;
          else if (req_iscan)   state_n = ST_ISCAN;
        end
      end
      ST_PAGE: begin
        if (page_rxid_p)   state_n = ST_MPR;
        else if (!req_page) state_n = ST_IDLE;
      end
      ST_INQ: begin
        if (!req_inquiry) state_n = ST_IDLE;
      end
      ST_PSCAN, ST_ISCAN: begin
        if ((state == ST_PSCAN) ? ps_rxid_p : is_rxid_p)
          state_n = (state == ST_PSCAN) ? ST_SPR : ST_IR;
        else if ((state == ST_PSCAN) ? !req_pscan : !req_iscan)
          state_n = ST_IDLE;
        else if (ms_tslot_p) begin
          if (half_cnt_inc >= scan_half_eff) begin
            half_odd_n = ~half_odd;
            half_cnt_n = 8'd0;
          end else begin
            half_cnt_n = half_cnt_inc;
          end
        end
      end
      ST_IR: begin
        if (ir_fhs_tx_p) begin
          isfhs_n = counter_isFHS + 5'd1;
          state_n = ST_ISCAN;
        end
      end
      ST_SPR: begin
        clkn1_n = ps_N_incr_p ? clkn1_cleared + 6'd1 : clkn1_cleared;
        if (psrxfhs_succ_p) fhs_ok_n = 1'b1;
        if (ps_N_incr_p && fhs_ok) state_n = ST_SCONN;
        else if (ms_tslot_p && to_cnt_inc >= PRTO) begin
          state_n   = slave_exit;
          timeout_n = 1'b1;
        end
      end
      ST_MPR: begin
        if (m_tslot_p) clke1_n = counter_clkE1 + 6'd1;
        if (mpr_fhs_ack_p) state_n = ST_MCONN;
        else if (ms_tslot_p && to_cnt_inc >= PRTO) begin
          state_n   = master_exit;
          timeout_n = 1'b1;
        end
      end
      ST_SCONN, ST_MCONN: begin
        if (detach_p)         state_n = ST_IDLE;
        else if (conn_poll_p) state_n = ST_CONN;
        else if (ms_tslot_p && to_cnt_inc >= NCTO) begin
          state_n   = (state == ST_SCONN) ? slave_exit : master_exit;
          timeout_n = 1'b1;
        end
      end
      ST_CONN: begin
        if (detach_p) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    entering = (state_n != state);
    timed_n  = (state_n == ST_SPR) || (state_n == ST_MPR) ||
               (state_n == ST_SCONN) || (state_n == ST_MCONN);

    if (!timed_n || entering) to_cnt_n = 6'd0;
    if (entering && (state_n == ST_PSCAN || state_n == ST_ISCAN) && state != ST_IR) begin
      half_cnt_n = 8'd0;
      half_odd_n = 1'b0;
    end
    if (entering && state_n == ST_ISCAN && state == ST_IDLE) isfhs_n = 5'd0;
    // A response counter leaving its phase snaps back to 1, even if it pulsed on the exit edge.
    if (state_n != ST_SPR) begin
      clkn1_n  = 6'd1;
      fhs_ok_n = 1'b0;
    end
    if (state_n != ST_MPR) clke1_n = 6'd1;
  end

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      state            <= ST_IDLE;
      half_odd         <= 1'b0;
      half_cnt         <= 8'd0;
      to_cnt           <= 6'd0;
      fhs_ok           <= 1'b0;
      counter_clkN1    <= 6'd1;
      counter_clkE1    <= 6'd1;
      counter_isFHS    <= 5'd0;
      resp_to_p        <= 1'b0;
      ps               <= 1'b0;
      gips             <= 1'b0;
      is               <= 1'b0;
      giis             <= 1'b0;
      page             <= 1'b0;
      inquiry          <= 1'b0;
      mpr              <= 1'b0;
      spr              <= 1'b0;
      ir               <= 1'b0;
      conns            <= 1'b0;
      prs_clock_frozen <= 1'b0;
      prm_clock_frozen <= 1'b0;
    end else begin
      state            <= state_n;
      half_odd         <= half_odd_n;
      half_cnt         <= half_cnt_n;
      to_cnt           <= to_cnt_n;
      fhs_ok           <= fhs_ok_n;
      counter_clkN1    <= clkn1_n;
      counter_clkE1    <= clke1_n;
      counter_isFHS    <= isfhs_n;
      resp_to_p        <= timeout_n;
      ps               <= (state_n == ST_PSCAN) && !(half_odd_n && regi_interlace_en);
      gips             <= (state_n == ST_PSCAN) && half_odd_n && regi_interlace_en;
      is               <= (state_n == ST_ISCAN) && !(half_odd_n && regi_interlace_en);
      giis             <= (state_n == ST_ISCAN) && half_odd_n && regi_interlace_en;
      page             <= (state_n == ST_PAGE);
      inquiry          <= (state_n == ST_INQ);
      mpr              <= (state_n == ST_MPR);
      spr              <= (state_n == ST_SPR);
      ir               <= (state_n == ST_IR);
      conns            <= (state_n == ST_SCONN) || (state_n == ST_MCONN) || (state_n == ST_CONN);
      prs_clock_frozen <= (state_n == ST_SPR);
      prm_clock_frozen <= (state_n == ST_MPR);
    end
  end

endmodule
